control_pipe: RTL and testbench
===============================

Name: control_pipe

Overview:
- Pipelined successor to the filter processor's combinational control decoder.
- Decodes each accepted instruction once and carries its control word down EX → MEM → WB stage registers, so every stage sees only its own signals.
- Adds interlocks: load-use stall, multi-cycle MUL hold in EX, and branch flush.
- Sits between fetch (valid/ready handshake) and the datapath (ALU, data memory, register file).

Parameters:
- OPCODE_W, 4, opcode width; the decode table covers values 0-15, and wider opcodes with nonzero upper bits decode as NOP.
- ALU_CTRL_W, 6, width of the ALU control code.
- REG_ADDR_W, 4, register address width.
- MUL_CYCLES, 3, cycles a MUL occupies EX; legal range is ≥1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  fetch presents an instruction.
- instr_ready  out  1  control accepts it this cycle.
- opcode  in  OPCODE_W  instruction opcode.
- cmp_flag  in  2  compare mode: 0 NOP, 1 LT, 2 EQ, 3 LE.
- rs_a, rs_b, rd  in  REG_ADDR_W  source and destination register addresses.
- branch_taken  in  1  from EX, meaningful only while ex_branch is 1.
- re_a, re_b  out  1  register-file read enables for the accepted instruction (combinational from inputs).
- ex_alu_control  out  ALU_CTRL_W  EX stage control.
- ex_sel_b  out  2  EX stage control.
- ex_alu_mux  out  1  EX stage control.
- ex_cmp_en  out  1  EX stage control.
- ex_branch  out  1  EX stage control.
- mem_we, mem_re  out  1  MEM stage control.
- wb_reg_we, wb_sel_data_out  out  1  WB stage control.
- wb_rd  out  REG_ADDR_W  WB destination register.

Behaviour:
- Decode table:
  - ALU codes: ADD0→0, SUB1→1, MUL2→2, AND3→3, OR4→4, XOR5→5, NOT6→6, MAX7→7, CMP8→8/9/10 for cmp_flag 1/2/3, SLL9→11, SLR10→12, LD12→0, ST13→0.
  - Everything else → 14, including CMP with flag 0, MOV11, BT14, NOP15.
  - sel_b = 1 for LD, 2 for ST, else 0.
  - alu_mux = 1 only for MOV.
  - cmp_en = 1 only for CMP; branch = 1 only for BT.
  - mem_re = 1 only for LD; mem_we = 1 only for ST; sel_data_out = 1 only for LD.
  - re_a = 0 for MOV, BT, NOP.
  - re_b = 0 for NOT, MOV, LD, BT, NOP.
  - reg_we = 0 for CMP, ST, BT, NOP.
- Bubble: a control word with alu_control=14 and every other field 0. All stage registers reset to bubble; wb_rd resets to 0.
- Acceptance: an instruction is accepted when instr_valid && instr_ready.
- Latency: an instruction accepted in cycle N drives EX in N+1, MEM in N+2, WB in N+3. A MUL adds MUL_CYCLES-1 to the MEM and WB times.
- Load-use stall: EX holds LD with rd = X, and the presented instruction has (re_a && rs_a == X) or (re_b && rs_b == X). Then:
  - instr_ready = 0;
  - a bubble enters EX next cycle;
  - exactly one stall cycle results.
  - MEM-stage results are assumed forwarded; no stall for them.
- MUL hold: when a MUL enters EX, a counter loads MUL_CYCLES-1. While the counter is nonzero:
  - EX holds its word;
  - MEM receives bubbles;
  - instr_ready = 0;
  - the counter decrements each cycle.
  - With MUL_CYCLES = 1 there is no hold.
- Branch flush: ex_branch && branch_taken causes:
  - any presented instruction is dropped (instr_ready = 1, not entered);
  - EX becomes a bubble next cycle.
  - Flush has priority over load-use stall.
  - branch_taken while ex_branch = 0 is ignored.
- instr_valid = 0 inserts a bubble into EX. MEM and WB always advance except during a MUL hold, where MEM takes bubbles while the older WB still drains.
- Reset asserted mid-operation: all stages immediately become bubbles and the counter clears. No stage recovers its old contents after release.
- instr_ready is combinational from current state and inputs.
- re_a and re_b are valid whenever instr_valid = 1, independent of stalls.

Decomposition:
- Shared package control_pkg holds:
  - opcode constants OP_ADD..OP_NOP;
  - ALU code constants including ALU_NOP = 14;
  - CMP flag constants;
  - the sel_b encodings;
  - a packed struct ctrl_word_t (alu_control, sel_b, alu_mux, cmp_en, branch, mem_we, mem_re, reg_we, sel_data_out, rd);
  - constant CTRL_BUBBLE.
- One sub-module, control_decode: purely combinational opcode + cmp_flag → ctrl_word_t. control_pipe instantiates it and adds the stage registers and hazard logic.

Test Plan:
- Reset then ADD(rs_a=1, rs_b=2, rd=3) accepted at cycle 0:
  - ex_alu_control=0 at cycle 1;
  - wb_reg_we=1 and wb_rd=3 at cycle 3;
  - all outputs equal bubble during reset.
- LD rd=5, then SUB rs_a=5:
  - instr_ready=0 for one cycle and a bubble reaches EX;
  - SUB enters EX two cycles after LD;
  - mem_re=1 exactly once.
- MUL with MUL_CYCLES=3, then ADD presented back-to-back:
  - ex_alu_control=2 for 3 cycles and instr_ready=0 for 2 cycles;
  - ADD reaches EX in cycle 4.
- BT in EX with branch_taken=1 and an ST presented:
  - ST is never seen: mem_we stays 0;
  - next EX word is the bubble with alu_control=14.
- CMP with cmp_flag=0,1,2,3:
  - ex_alu_control = 14, 8, 9, 10 respectively;
  - ex_cmp_en=1 throughout;
  - wb_reg_we=0 for all four.
- rst_n pulsed low mid-MUL hold:
  - outputs become bubble asynchronously;
  - instr_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/control_pkg.sv
// Shared control-path definitions: opcodes, ALU codes, operand selects, stage control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package control_pkg;

  localparam int CW_ALU_W = 6;
  localparam int CW_REG_W = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_MAX = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
  localparam logic [3:0] OP_SLL = 4'd9;
  localparam logic [3:0] OP_SLR = 4'd10;
  localparam logic [3:0] OP_MOV = 4'd11;
  localparam logic [3:0] OP_LD  = 4'd12;
  localparam logic [3:0] OP_ST  = 4'd13;
  localparam logic [3:0] OP_BT  = 4'd14;
  localparam logic [3:0] OP_NOP = 4'd15;

  localparam logic [CW_ALU_W-1:0] ALU_ADD = 6'd0;
  localparam logic [CW_ALU_W-1:0] ALU_SUB = 6'd1;
  localparam logic [CW_ALU_W-1:0] ALU_MUL = 6'd2;
  localparam logic [CW_ALU_W-1:0] ALU_AND = 6'd3;
  localparam logic [CW_ALU_W-1:0] ALU_OR  = 6'd4;
  localparam logic [CW_ALU_W-1:0] ALU_XOR = 6'd5;
  localparam logic [CW_ALU_W-1:0] ALU_NOT = 6'd6;
  localparam logic [CW_ALU_W-1:0] ALU_MAX = 6'd7;
  localparam logic [CW_ALU_W-1:0] ALU_LT  = 6'd8;
  localparam logic [CW_ALU_W-1:0] ALU_EQ  = 6'd9;
  localparam logic [CW_ALU_W-1:0] ALU_LE  = 6'd10;
  localparam logic [CW_ALU_W-1:0] ALU_SLL = 6'd11;
  localparam logic [CW_ALU_W-1:0] ALU_SLR = 6'd12;
  localparam logic [CW_ALU_W-1:0] ALU_NOP = 6'd14;

  localparam logic [1:0] CMP_NOP = 2'd0;
  localparam logic [1:0] CMP_LT  = 2'd1;
  localparam logic [1:0] CMP_EQ  = 2'd2;
  localparam logic [1:0] CMP_LE  = 2'd3;

  localparam logic [1:0] SEL_B_REG = 2'd0;
  localparam logic [1:0] SEL_B_LD  = 2'd1;
  localparam logic [1:0] SEL_B_ST  = 2'd2;

  typedef struct packed {
    logic [CW_ALU_W-1:0] alu_control;
    logic [1:0]          sel_b;
    logic                alu_mux;
    logic                cmp_en;
    logic                branch;
    logic                mem_we;
    logic                mem_re;
    logic                reg_we;
    logic                sel_data_out;
    logic [CW_REG_W-1:0] rd;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '{
    alu_control:  ALU_NOP,
    sel_b:        SEL_B_REG,
    alu_mux:      1'b0,
    cmp_en:       1'b0,
    branch:       1'b0,
    mem_we:       1'b0,
    mem_re:       1'b0,
    reg_we:       1'b0,
    sel_data_out: 1'b0,
    rd:           '0
  };

endpackage

// File: rtl/control_decode.sv
// Opcode + compare mode -> stage control word and register-file read enables.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the word is used.
module control_decode
  import control_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [1:0]          cmp_flag,
  output ctrl_word_t          ctrl,
  output logic                re_a,
  output logic                re_b
);

  logic [3:0] op;

  // Table decode; opcodes with any bit above the low nibble set behave as NOP.
  always_comb begin
    op = opcode[3:0];
    if ((opcode >> 4) != '0) op = OP_NOP;
    ctrl        = CTRL_BUBBLE;
    ctrl.reg_we = 1'b1;
    re_a        = 1'b1;
    re_b        = 1'b1;
    case (op)
      OP_ADD: ctrl.alu_control = ALU_ADD;
      OP_SUB: ctrl.alu_control = ALU_SUB;
      OP_MUL: ctrl.alu_control = ALU_MUL;
      OP_AND: ctrl.alu_control = ALU_AND;
      OP_OR:  ctrl.alu_control = ALU_OR;
      OP_XOR: ctrl.alu_control = ALU_XOR;
      OP_NOT: begin
        ctrl.alu_control = ALU_NOT;
        re_b             = 1'b0;
      end
      OP_MAX: ctrl.alu_control = ALU_MAX;
      OP_CMP: begin
        ctrl.cmp_en = 1'b1;
        ctrl.reg_we = 1'b0;
        case (cmp_flag)
          CMP_LT:  ctrl.alu_control = ALU_LT;
          CMP_EQ:  ctrl.alu_control = ALU_EQ;
          CMP_LE:  ctrl.alu_control = ALU_LE;
          default: ctrl.alu_control = ALU_NOP;
        endcase
      end
      OP_SLL: ctrl.alu_control = ALU_SLL;
      OP_SLR: ctrl.alu_control = ALU_SLR;
      OP_MOV: begin
        ctrl.alu_mux = 1'b1;
        re_a         = 1'b0;
        re_b         = 1'b0;
      end
      OP_LD: begin
        ctrl.alu_control  = ALU_ADD;
        ctrl.sel_b        = SEL_B_LD;
        ctrl.mem_re       = 1'b1;
        ctrl.sel_data_out = 1'b1;
        re_b              = 1'b0;
      end
      OP_ST: begin
        ctrl.alu_control = ALU_ADD;
        ctrl.sel_b       = SEL_B_ST;
        ctrl.mem_we      = 1'b1;
        ctrl.reg_we      = 1'b0;
      end
      OP_BT: begin
        ctrl.branch = 1'b1;
        ctrl.reg_we = 1'b0;
        re_a        = 1'b0;
        re_b        = 1'b0;
      end
      default: begin
        ctrl.reg_we = 1'b0;
        re_a        = 1'b0;
        re_b        = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// Pipelined control: decode once, carry control word EX -> MEM -> WB with hazard interlocks.
// Latency: accept in N -> EX N+1, MEM N+2, WB N+3; a MUL adds MUL_CYCLES-1 to MEM/WB.
// Backpressure: instr_ready drops for load-use and MUL hold; a taken branch accepts and drops.
module control_pipe
  import control_pkg::*;
#(
  parameter int OPCODE_W   = 4,
  parameter int ALU_CTRL_W = 6,
  parameter int REG_ADDR_W = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [1:0]            cmp_flag,
  input  logic [REG_ADDR_W-1:0] rs_a,
  input  logic [REG_ADDR_W-1:0] rs_b,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  branch_taken,
  output logic                  re_a,
  output logic                  re_b,
  output logic [ALU_CTRL_W-1:0] ex_alu_control,
  output logic [1:0]            ex_sel_b,
  output logic                  ex_alu_mux,
  output logic                  ex_cmp_en,
  output logic                  ex_branch,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic                  wb_reg_we,
  output logic                  wb_sel_data_out,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  ctrl_word_t          dec_word;
  ctrl_word_t          ex_q, ex_d;
  logic                mem_we_q, mem_re_q, mem_reg_we_q, mem_sel_q;
  logic [CW_REG_W-1:0] mem_rd_q;
  logic                wb_reg_we_q, wb_sel_q;
  logic [CW_REG_W-1:0] wb_rd_q;
  logic [CNT_W-1:0]    mul_cnt, mul_cnt_d;
  logic                hold, flush, load_use, accept;

  control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode   (opcode),
    .cmp_flag (cmp_flag),
    .ctrl     (dec_word),
    .re_a     (re_a),
    .re_b     (re_b)
  );

  // Hazard detection: MUL occupancy, taken branch in EX, and a load whose result is needed now.
  always_comb begin
    hold     = (mul_cnt != '0);
    flush    = ex_q.branch && branch_taken;
    load_use = instr_valid && ex_q.mem_re &&
               ((re_a && (CW_REG_W'(rs_a) == ex_q.rd)) ||
                (re_b && (CW_REG_W'(rs_b) == ex_q.rd)));
    // A flush consumes the presented instruction so fetch can move on to the target.
    instr_ready = flush || (!hold && !load_use);
    accept      = instr_valid && instr_ready && !flush;
  end

  // Next EX word and MUL occupancy counter.
  always_comb begin
    ex_d      = CTRL_BUBBLE;
    mul_cnt_d = '0;
    if (hold) begin
      ex_d      = ex_q;
      mul_cnt_d = mul_cnt - 1'b1;
    end else if (accept) begin
      ex_d    = dec_word;
      ex_d.rd = CW_REG_W'(rd);
      if (dec_word.alu_control == ALU_MUL) mul_cnt_d = MUL_LOAD;
    end
  end

  // Stage registers; MEM takes bubbles while EX is held, WB always drains MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= CTRL_BUBBLE;
      mul_cnt      <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_reg_we_q <= 1'b0;
      mem_sel_q    <= 1'b0;
      mem_rd_q     <= '0;
      wb_reg_we_q  <= 1'b0;
      wb_sel_q     <= 1'b0;
      wb_rd_q      <= '0;
    end else begin
      ex_q         <= ex_d;
      mul_cnt      <= mul_cnt_d;
      mem_we_q     <= hold ? 1'b0 : ex_q.mem_we;
      mem_re_q     <= hold ? 1'b0 : ex_q.mem_re;
      mem_reg_we_q <= hold ? 1'b0 : ex_q.reg_we;
      mem_sel_q    <= hold ? 1'b0 : ex_q.sel_data_out;
      mem_rd_q     <= hold ? '0   : ex_q.rd;
      wb_reg_we_q  <= mem_reg_we_q;
      wb_sel_q     <= mem_sel_q;
      wb_rd_q      <= mem_rd_q;
    end
  end

  assign ex_alu_control  = ALU_CTRL_W'(ex_q.alu_control);
  assign ex_sel_b        = ex_q.sel_b;
  assign ex_alu_mux      = ex_q.alu_mux;
  assign ex_cmp_en       = ex_q.cmp_en;
  assign ex_branch       = ex_q.branch;
  assign mem_we          = mem_we_q;
  assign mem_re          = mem_re_q;
  assign wb_reg_we       = wb_reg_we_q;
  assign wb_sel_data_out = wb_sel_q;
  assign wb_rd           = REG_ADDR_W'(wb_rd_q);

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: directed scenarios plus random traffic against a schedule-based model.
// Latency: model books each accepted instruction into future EX/MEM/WB slots.
// Backpressure: model predicts instr_ready from the slot contents and MUL busy window.
module tb_control_pipe;

  localparam int MUL_CYCLES = 3;
  localparam int MAXC       = 2048;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] opcode = 4'd15;
  logic [1:0] cmp_flag = 2'd0;
  logic [3:0] rs_a = '0, rs_b = '0, rd = '0;
  logic       branch_taken = 1'b0;
  logic       re_a, re_b;
  logic [5:0] ex_alu_control;
  logic [1:0] ex_sel_b;
  logic       ex_alu_mux, ex_cmp_en, ex_branch;
  logic       mem_we, mem_re, wb_reg_we, wb_sel_data_out;
  logic [3:0] wb_rd;

  always #5 clk = ~clk;

  control_pipe #(.OPCODE_W(4), .ALU_CTRL_W(6), .REG_ADDR_W(4), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .cmp_flag(cmp_flag), .rs_a(rs_a), .rs_b(rs_b), .rd(rd),
    .branch_taken(branch_taken), .re_a(re_a), .re_b(re_b),
    .ex_alu_control(ex_alu_control), .ex_sel_b(ex_sel_b), .ex_alu_mux(ex_alu_mux),
    .ex_cmp_en(ex_cmp_en), .ex_branch(ex_branch), .mem_we(mem_we), .mem_re(mem_re),
    .wb_reg_we(wb_reg_we), .wb_sel_data_out(wb_sel_data_out), .wb_rd(wb_rd)
  );

  typedef struct packed {
    logic [5:0] alu;
    logic [1:0] sel_b;
    logic       mux, cmp, br, we, re, rwe, sdo;
    logic [3:0] rd;
  } ref_w_t;

  ref_w_t ex_s[MAXC];
  ref_w_t mem_s[MAXC];
  ref_w_t wb_s[MAXC];
  int     cyc = 0;
  int     busy_until = -1;
  int     total = 0;
  int     bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic ref_w_t bub();
    ref_w_t w;
    w = '0;
    w.alu = 6'd14;
    return w;
  endfunction

  // Reference decode written straight from the instruction table.
  function automatic ref_w_t ref_decode(logic [3:0] op, logic [1:0] f, logic [3:0] d);
    ref_w_t w;
    w     = bub();
    w.rd  = d;
    w.rwe = !(op inside {4'd8, 4'd13, 4'd14, 4'd15});
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: w.alu = {2'b00, op};
      4'd8: begin
        w.cmp = 1'b1;
        w.alu = (f == 2'd0) ? 6'd14 : 6'd7 + {4'd0, f};
      end
      4'd9:  w.alu = 6'd11;
      4'd10: w.alu = 6'd12;
      4'd11: w.mux = 1'b1;
      4'd12: begin w.alu = 6'd0; w.sel_b = 2'd1; w.re = 1'b1; w.sdo = 1'b1; end
      4'd13: begin w.alu = 6'd0; w.sel_b = 2'd2; w.we = 1'b1; end
      4'd14: w.br = 1'b1;
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic ref_ra(logic [3:0] op);
    return !(op inside {4'd11, 4'd14, 4'd15});
  endfunction

  function automatic logic ref_rb(logic [3:0] op);
    return !(op inside {4'd6, 4'd11, 4'd12, 4'd14, 4'd15});
  endfunction

  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) begin
      ex_s[i]  = bub();
      mem_s[i] = bub();
      wb_s[i]  = bub();
    end
    busy_until = -1;
  endtask

  // One clock: drive, check everything at the falling edge, book the accepted instruction.
  task automatic step(input logic v, input logic [3:0] op, input logic [1:0] f,
                      input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                      input logic bt, output logic acc);
    ref_w_t cur, nw;
    logic   flush, lu, ra, rb, exp_rdy;
    int     extra;
    instr_valid = v; opcode = op; cmp_flag = f; rs_a = a; rs_b = b; rd = d; branch_taken = bt;
    @(negedge clk);
    cur   = ex_s[cyc];
    nw    = ref_decode(op, f, d);
    ra    = ref_ra(op);
    rb    = ref_rb(op);
    flush = cur.br && bt;
    lu    = v && cur.re && ((ra && a == cur.rd) || (rb && b == cur.rd));
    exp_rdy = flush || (cyc > busy_until && !lu);
    chk("instr_ready", {31'd0, instr_ready}, {31'd0, exp_rdy});
    if (v) chk("re_ab", {30'd0, re_a, re_b}, {30'd0, ra, rb});
    chk("ex_word", {21'd0, ex_alu_control, ex_sel_b, ex_alu_mux, ex_cmp_en, ex_branch},
        {21'd0, cur.alu, cur.sel_b, cur.mux, cur.cmp, cur.br});
    chk("mem_ctl", {30'd0, mem_we, mem_re}, {30'd0, mem_s[cyc].we, mem_s[cyc].re});
    chk("wb_ctl", {26'd0, wb_reg_we, wb_sel_data_out, wb_rd},
        {26'd0, wb_s[cyc].rwe, wb_s[cyc].sdo, wb_s[cyc].rd});
    acc = v && exp_rdy && !flush;
    if (acc) begin
      extra = (op == 4'd2) ? MUL_CYCLES - 1 : 0;
      for (int k = 1; k <= 1 + extra; k++) ex_s[cyc + k] = nw;
      mem_s[cyc + 2 + extra] = nw;
      wb_s[cyc + 3 + extra]  = nw;
      if (op == 4'd2) busy_until = cyc + extra;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [3:0] op, input logic [1:0] f,
                      input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) step(1'b1, op, f, a, b, d, 1'b0, acc);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 4'd15, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, acc);
  endtask

  // Asynchronous reset pulse that starts between clock edges.
  task automatic reset_pulse();
    instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ex", {21'd0, ex_alu_control, ex_sel_b, ex_alu_mux, ex_cmp_en, ex_branch},
        {21'd0, 6'd14, 5'd0});
    chk("rst_mem", {30'd0, mem_we, mem_re}, 32'd0);
    chk("rst_wb", {26'd0, wb_reg_we, wb_sel_data_out, wb_rd}, 32'd0);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic acc;
    clear_model();
    @(posedge clk);
    #1;
    reset_pulse();
    cyc = 0;

    // ADD r3 = r1 + r2, then drain.
    send(4'd0, 2'd0, 4'd1, 4'd2, 4'd3);
    idle(4);

    // Load-use: LD r5 then SUB reading r5.
    send(4'd12, 2'd0, 4'd0, 4'd0, 4'd5);
    send(4'd1, 2'd0, 4'd5, 4'd1, 4'd6);
    idle(4);

    // MUL hold followed by an ADD presented back-to-back.
    send(4'd2, 2'd0, 4'd1, 4'd2, 4'd7);
    send(4'd0, 2'd0, 4'd3, 4'd4, 4'd8);
    idle(6);

    // Taken branch drops the presented ST.
    send(4'd14, 2'd0, 4'd0, 4'd0, 4'd0);
    step(1'b1, 4'd13, 2'd0, 4'd1, 4'd2, 4'd0, 1'b1, acc);
    chk("st_dropped", {31'd0, acc}, 32'd0);
    idle(4);

    // CMP in every compare mode.
    for (int f = 0; f < 4; f++) send(4'd8, 2'(f), 4'd1, 4'd2, 4'd9);
    idle(4);

    // Reset in the middle of a MUL hold.
    send(4'd2, 2'd0, 4'd1, 4'd2, 4'd3);
    reset_pulse();
    idle(2);

    // Random traffic with small register range to provoke hazards.
    for (int i = 0; i < 700; i++) begin
      if (i == 350) reset_pulse();
      step(($urandom_range(0, 9) < 8), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), acc);
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
